// File: rtl/verificador_tiro.sv
// Shot resolution: scans the defender's fleet memory for the shot cell, writes back
// the first unhit matching ship with the cell flagged and its count decremented.
module verificador_tiro #(
    parameter int NUM_ENTRADAS  = 11,
    parameter int TAM_TABULEIRO = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  x_tiro,
    input  logic [3:0]  y_tiro,
    input  logic        jogador,
    input  logic [63:0] vetor_leitura,
    output logic        mem_sel,
    output logic [4:0]  read_addr,
    output logic [4:0]  write_addr,
    output logic [63:0] vetor,
    output logic        wrep1,
    output logic        wrep2,
    output logic        ocupado,
    output logic        done,
    output logic        acerto,
    output logic        repetido,
    output logic        invalido,
    output logic        afundou,
    output logic [2:0]  tipo_afundado,
    output logic        frota_destruida,
    output logic [2:0]  estado_dbg
);

    typedef enum logic [2:0] {IDLE, LER, COMPARAR, ESCREVER, FIM} estado_t;

    localparam logic [4:0] ULTIMO = 5'(NUM_ENTRADAS - 1);
    localparam logic [3:0] TAM    = 4'(TAM_TABULEIRO);

    estado_t     estado_q, estado_d;
    logic [3:0]  x_q, x_d, y_q, y_d;
    logic        mem_sel_q, mem_sel_d;
    logic [4:0]  read_addr_q, read_addr_d, write_addr_q, write_addr_d;
    logic [63:0] vetor_q, vetor_d;
    logic        acerto_q, acerto_d, repetido_q, repetido_d, invalido_q, invalido_d;
    logic        afundou_q, afundou_d, frota_q, frota_d, achou_q, achou_d;
    logic [2:0]  tipo_q, tipo_d;
    logic [6:0]  soma_q, soma_d;

    // Only the cells a ship type actually has take part in the compare.
    function automatic logic [2:0] num_celulas(input logic [2:0] tipo);
        case (tipo)
            3'd0:    return 3'd5;
            3'd1:    return 3'd4;
            3'd2:    return 3'd3;
            3'd3:    return 3'd2;
            3'd4:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    logic [2:0]  tipo_lido, n_cel, idx;
    logic [3:0]  cont_lido, cont_novo;
    logic        casa, flag_lida, escreve;
    logic [63:0] vetor_novo;

    always_comb begin
        tipo_lido = vetor_leitura[2:0];
        cont_lido = vetor_leitura[46:43];
        n_cel     = num_celulas(tipo_lido);
        casa      = 1'b0;
        idx       = 3'd0;
        // Descending so the lowest matching cell index wins.
        for (int i = 4; i >= 0; i--) begin
            if (3'(i) < n_cel && cont_lido != 4'd0 &&
                vetor_leitura[6+8*i -: 4] == x_q && vetor_leitura[10+8*i -: 4] == y_q) begin
                casa = 1'b1;
                idx  = 3'(i);
            end
        end
        flag_lida  = vetor_leitura[47 + int'(idx)];
        cont_novo  = (cont_lido != 4'd0) ? cont_lido - 4'd1 : 4'd0;
        escreve    = casa && !flag_lida && !achou_q;
        vetor_novo = vetor_leitura;
        vetor_novo[47 + int'(idx)] = 1'b1;
        vetor_novo[46:43] = cont_novo;
    end

    always_comb begin
        estado_d     = estado_q;
        x_d          = x_q;
        y_d          = y_q;
        mem_sel_d    = mem_sel_q;
        read_addr_d  = read_addr_q;
        write_addr_d = write_addr_q;
        vetor_d      = vetor_q;
        acerto_d     = acerto_q;
        repetido_d   = repetido_q;
        invalido_d   = invalido_q;
        afundou_d    = afundou_q;
        tipo_d       = tipo_q;
        frota_d      = frota_q;
        achou_d      = achou_q;
        soma_d       = soma_q;
        case (estado_q)
            IDLE: begin
                if (start) begin
                    x_d        = x_tiro;
                    y_d        = y_tiro;
                    mem_sel_d  = ~jogador;
                    acerto_d   = 1'b0;
                    repetido_d = 1'b0;
                    invalido_d = 1'b0;
                    afundou_d  = 1'b0;
                    tipo_d     = 3'd0;
                    frota_d    = 1'b0;
                    achou_d    = 1'b0;
                    soma_d     = 7'd0;
                    if (x_tiro >= TAM || y_tiro >= TAM) begin
                        invalido_d = 1'b1;
                        estado_d   = FIM;
                    end else begin
                        read_addr_d = 5'd0;
                        estado_d    = LER;
                    end
                end
            end
            LER: estado_d = COMPARAR;
            COMPARAR: begin
                soma_d = soma_q + 7'(escreve ? cont_novo : cont_lido);
                if (escreve) begin
                    vetor_d      = vetor_novo;
                    write_addr_d = read_addr_q;
                    acerto_d     = 1'b1;
                    achou_d      = 1'b1;
                    if (cont_novo == 4'd0) begin
                        afundou_d = 1'b1;
                        tipo_d    = tipo_lido;
                    end
                    estado_d = ESCREVER;
                end else begin
                    if (casa && flag_lida) repetido_d = 1'b1;
                    if (read_addr_q == ULTIMO) begin
                        frota_d  = (soma_d == 7'd0);
                        estado_d = FIM;
                    end else begin
                        read_addr_d = read_addr_q + 5'd1;
                        estado_d    = LER;
                    end
                end
            end
            ESCREVER: begin
                if (read_addr_q == ULTIMO) begin
                    frota_d  = (soma_q == 7'd0);
                    estado_d = FIM;
                end else begin
                    read_addr_d = read_addr_q + 5'd1;
                    estado_d    = LER;
                end
            end
            FIM:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= IDLE;
            x_q          <= 4'd0;
            y_q          <= 4'd0;
            mem_sel_q    <= 1'b0;
            read_addr_q  <= 5'd0;
            write_addr_q <= 5'd0;
            vetor_q      <= 64'd0;
            acerto_q     <= 1'b0;
            repetido_q   <= 1'b0;
            invalido_q   <= 1'b0;
            afundou_q    <= 1'b0;
            tipo_q       <= 3'd0;
            frota_q      <= 1'b0;
            achou_q      <= 1'b0;
            soma_q       <= 7'd0;
        end else begin
            estado_q     <= estado_d;
            x_q          <= x_d;
            y_q          <= y_d;
            mem_sel_q    <= mem_sel_d;
            read_addr_q  <= read_addr_d;
            write_addr_q <= write_addr_d;
            vetor_q      <= vetor_d;
            acerto_q     <= acerto_d;
            repetido_q   <= repetido_d;
            invalido_q   <= invalido_d;
            afundou_q    <= afundou_d;
            tipo_q       <= tipo_d;
            frota_q      <= frota_d;
            achou_q      <= achou_d;
            soma_q       <= soma_d;
        end
    end

    // Write strobes decode straight from state so an async reset kills them at once.
    assign wrep1           = (estado_q == ESCREVER) && !mem_sel_q;
    assign wrep2           = (estado_q == ESCREVER) && mem_sel_q;
    assign ocupado         = (estado_q != IDLE);
    assign done            = (estado_q == FIM);
    assign mem_sel         = mem_sel_q;
    assign read_addr       = read_addr_q;
    assign write_addr      = write_addr_q;
    assign vetor           = vetor_q;
    assign acerto          = acerto_q;
    assign repetido        = repetido_q;
    assign invalido        = invalido_q;
    assign afundou         = afundou_q;
    assign tipo_afundado   = tipo_q;
    assign frota_destruida = frota_q;
    assign estado_dbg      = estado_q;

endmodule

// File: tb/tb_verificador_tiro.sv
// Directed bench for verificador_tiro: two fleet memories with one-cycle read latency,
// hand-built ship vectors and hand-computed results.
module tb_verificador_tiro;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  x_tiro, y_tiro;
    logic        jogador;
    logic [63:0] vetor_leitura;
    logic        mem_sel;
    logic [4:0]  read_addr, write_addr;
    logic [63:0] vetor;
    logic        wrep1, wrep2, ocupado, done, acerto, repetido, invalido, afundou;
    logic [2:0]  tipo_afundado;
    logic        frota_destruida;
    logic [2:0]  estado_dbg;

    verificador_tiro dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_tiro(x_tiro), .y_tiro(y_tiro),
        .jogador(jogador), .vetor_leitura(vetor_leitura), .mem_sel(mem_sel),
        .read_addr(read_addr), .write_addr(write_addr), .vetor(vetor),
        .wrep1(wrep1), .wrep2(wrep2), .ocupado(ocupado), .done(done),
        .acerto(acerto), .repetido(repetido), .invalido(invalido), .afundou(afundou),
        .tipo_afundado(tipo_afundado), .frota_destruida(frota_destruida),
        .estado_dbg(estado_dbg)
    );

    always #5 clk = ~clk;

    logic [63:0] mem_p1 [11];
    logic [63:0] mem_p2 [11];
    int          n_rd = 0, n_wr1 = 0, n_wr2 = 0;
    logic [4:0]  last_waddr = 5'd0;
    logic [63:0] last_vetor = 64'd0;
    int          total = 0, bad = 0;

    always @(posedge clk) begin
        if (read_addr < 5'd11)
            vetor_leitura <= mem_sel ? mem_p2[read_addr] : mem_p1[read_addr];
        else
            vetor_leitura <= 64'd0;
        if (estado_dbg == 3'd1) n_rd <= n_rd + 1;
        if (wrep1) n_wr1 <= n_wr1 + 1;
        if (wrep2) n_wr2 <= n_wr2 + 1;
        if (wrep1 || wrep2) begin
            last_waddr <= write_addr;
            last_vetor <= vetor;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ship_h(input logic [2:0] t, input int x0, input int y, input int n);
        logic [63:0] v;
        v = 64'd0;
        v[2:0] = t;
        for (int i = 0; i < n; i++) begin
            v[6+8*i -: 4]  = 4'(x0 + i);
            v[10+8*i -: 4] = 4'(y);
        end
        v[46:43] = 4'(n);
        return v;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 11; i++) begin
            mem_p1[i] = 64'd0;
            mem_p2[i] = 64'd0;
        end
    endtask

    // Launches one shot and waits (bounded) for done; optionally pulses start mid-scan.
    task automatic run_shot(input logic [3:0] x, input logic [3:0] y, input logic j,
                            input bit inject, output int lat, output int rd,
                            output int w1, output int w2);
        int r0, a0, b0;
        r0 = n_rd; a0 = n_wr1; b0 = n_wr2;
        x_tiro = x; y_tiro = y; jogador = j; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (inject && lat == 5) begin
                start = 1'b1; x_tiro = 4'd6; y_tiro = 4'd5; jogador = ~j;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
        @(posedge clk); #1;
        chk("idle_after_done", ocupado, 1'b0);
        rd = n_rd - r0; w1 = n_wr1 - a0; w2 = n_wr2 - b0;
    endtask

    int lat, rd, w1, w2;
    logic [63:0] hit_vec, exp_v;

    initial begin
        rst_n = 1'b0; start = 1'b0; x_tiro = 4'd0; y_tiro = 4'd0; jogador = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_sel", mem_sel, 1'b0);
        chk("rst_read_addr", read_addr, 5'd0);
        chk("rst_write_addr", write_addr, 5'd0);
        chk("rst_vetor", vetor, 64'd0);
        chk("rst_flags", {wrep1, wrep2, ocupado, done, acerto, repetido, invalido, afundou, frota_destruida}, 9'd0);
        chk("rst_estado", estado_dbg, 3'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Miss on a carrier at (2..6,3) in P2 memory
        mem_p2[0] = ship_h(3'd0, 2, 3, 5);
        run_shot(4'd8, 4'd8, 1'b0, 0, lat, rd, w1, w2);
        chk("miss_latency", lat, 23);
        chk("miss_acerto", acerto, 1'b0);
        chk("miss_writes", w1 + w2, 0);
        chk("miss_reads", rd, 11);
        chk("miss_mem_sel", mem_sel, 1'b1);
        chk("miss_frota", frota_destruida, 1'b0);

        // Hit cell 2 of the carrier
        run_shot(4'd4, 4'd3, 1'b0, 0, lat, rd, w1, w2);
        hit_vec = ship_h(3'd0, 2, 3, 5);
        hit_vec[46:43] = 4'd4;
        hit_vec[49] = 1'b1;
        chk("hit_latency", lat, 24);
        chk("hit_wrep2", w2, 1);
        chk("hit_wrep1", w1, 0);
        chk("hit_waddr", last_waddr, 5'd0);
        chk("hit_vetor", last_vetor, hit_vec);
        chk("hit_acerto", acerto, 1'b1);
        chk("hit_afundou", {afundou, tipo_afundado}, 4'd0);
        chk("hit_repetido", repetido, 1'b0);
        chk("hit_frota", frota_destruida, 1'b0);

        // Same shot again against the written-back vector
        mem_p2[0] = hit_vec;
        run_shot(4'd4, 4'd3, 1'b0, 0, lat, rd, w1, w2);
        chk("rep_latency", lat, 23);
        chk("rep_repetido", repetido, 1'b1);
        chk("rep_acerto", acerto, 1'b0);
        chk("rep_writes", w1 + w2, 0);

        // Sink the only ship of P1: submarine at (0,0)
        mem_p1[0] = ship_h(3'd4, 0, 0, 1);
        run_shot(4'd0, 4'd0, 1'b1, 0, lat, rd, w1, w2);
        exp_v = ship_h(3'd4, 0, 0, 1);
        exp_v[46:43] = 4'd0;
        exp_v[47] = 1'b1;
        chk("sink_latency", lat, 24);
        chk("sink_wrep1", w1, 1);
        chk("sink_wrep2", w2, 0);
        chk("sink_vetor", last_vetor, exp_v);
        chk("sink_mem_sel", mem_sel, 1'b0);
        chk("sink_afundou", afundou, 1'b1);
        chk("sink_tipo", tipo_afundado, 3'd4);
        chk("sink_frota", frota_destruida, 1'b1);

        // Two-cell ship: padding cells read as (0,0) must not match
        mem_p1[0] = ship_h(3'd3, 5, 5, 2);
        run_shot(4'd0, 4'd0, 1'b1, 0, lat, rd, w1, w2);
        chk("pad_acerto", acerto, 1'b0);
        chk("pad_repetido", repetido, 1'b0);
        chk("pad_writes", w1 + w2, 0);
        chk("pad_frota", frota_destruida, 1'b0);

        // Hit in a later entry: write address follows the entry
        mem_p1[3] = ship_h(3'd2, 7, 9, 3);
        run_shot(4'd9, 4'd9, 1'b1, 0, lat, rd, w1, w2);
        exp_v = ship_h(3'd2, 7, 9, 3);
        exp_v[46:43] = 4'd2;
        exp_v[49] = 1'b1;
        chk("e3_waddr", last_waddr, 5'd3);
        chk("e3_vetor", last_vetor, exp_v);
        chk("e3_wrep1", w1, 1);
        chk("e3_afundou", afundou, 1'b0);

        // Invalid coordinates
        run_shot(4'd10, 4'd2, 1'b0, 0, lat, rd, w1, w2);
        chk("inv_latency", lat, 1);
        chk("inv_invalido", invalido, 1'b1);
        chk("inv_reads", rd, 0);
        chk("inv_writes", w1 + w2, 0);
        chk("inv_frota", frota_destruida, 1'b0);
        run_shot(4'd3, 4'd15, 1'b1, 0, lat, rd, w1, w2);
        chk("inv_y_invalido", invalido, 1'b1);
        chk("inv_y_latency", lat, 1);

        // Empty fleet
        for (int i = 0; i < 11; i++) mem_p1[i] = 64'd0;
        run_shot(4'd5, 4'd5, 1'b1, 0, lat, rd, w1, w2);
        chk("empty_frota", frota_destruida, 1'b1);
        chk("empty_invalido", invalido, 1'b0);
        chk("empty_acerto", acerto, 1'b0);

        // Reset while writing back
        x_tiro = 4'd5; y_tiro = 4'd3; jogador = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (estado_dbg != 3'd3 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("pre_rst_wrep2", wrep2, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_wrep2", wrep2, 1'b0);
        chk("arst_flags", {wrep1, ocupado, done, acerto, mem_sel}, 5'd0);
        chk("arst_addrs", {read_addr, write_addr}, 10'd0);
        chk("arst_vetor", vetor, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Full run afterwards, with start pulses while busy
        run_shot(4'd5, 4'd3, 1'b0, 1, lat, rd, w1, w2);
        exp_v = hit_vec;
        exp_v[46:43] = 4'd3;
        exp_v[50] = 1'b1;
        chk("post_latency", lat, 24);
        chk("post_wrep2", w2, 1);
        chk("post_wrep1", w1, 0);
        chk("post_vetor", last_vetor, exp_v);
        chk("post_mem_sel", mem_sel, 1'b1);
        chk("post_acerto", acerto, 1'b1);
        chk("post_idle", ocupado, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
